// File: rtl/mips_data_memory_if.sv
// -----------------------------------------------------------------------------
// mips_data_memory_if
//   Bus between the MEM stage of the MIPS pipeline core and the word-organised
//   data memory.
//
//   Signals:
//     addr        byte address from the EX/MEM ALU result
//     memwrite    store enable from the EX/MEM stage
//     memread     load enable from the EX/MEM stage
//     write_data  store data from the EX/MEM register
//     read_data   load data returned to the MEM/WB stage (combinational)
//
//   Modports:
//     master  core side (drives the address, the enables and the store data)
//     slave   memory side (returns the load data)
// -----------------------------------------------------------------------------
interface mips_data_memory_if;
  logic [31:0] addr;
  logic        memwrite;
  logic        memread;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output addr,
    output memwrite,
    output memread,
    output write_data,
    input  read_data
  );

  modport slave (
    input  addr,
    input  memwrite,
    input  memread,
    input  write_data,
    output read_data
  );
endinterface : mips_data_memory_if

// File: rtl/mips_data_memory.sv
// -----------------------------------------------------------------------------
// mips_data_memory
//   Word-organised data memory serving the MEM stage of the MIPS pipeline core.
//   Stores are full 32-bit words committed on the rising clock edge. Loads are
//   combinational, so the load data is valid in the same cycle as the address.
//
//   Parameters:
//     DEPTH   number of 32-bit words (power of two)
//     ADDR_W  word-index width, log2(DEPTH)
//
//   Ports:
//     clk    system clock; stores commit on the rising edge
//     reset  asynchronous active-low reset; clears every word at once
//     bus    mips_data_memory_if.slave
//              addr[ADDR_W+1:2] selects the word. addr[1:0] is ignored, so a
//              misaligned access hits the containing word. The upper address
//              bits are ignored, so out-of-range addresses wrap modulo DEPTH.
//              read_data is 0 whenever memread is low.
// -----------------------------------------------------------------------------
module mips_data_memory #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  mips_data_memory_if.slave bus
);

  // Selects the word addressed by a byte address; the byte offset and any
  // address bits above the array are deliberately dropped.
  function automatic logic [ADDR_W-1:0] word_index(input logic [31:0] byte_addr);
    return byte_addr[ADDR_W+1:2];
  endfunction

  logic [31:0]       mem_r [DEPTH];
  logic [ADDR_W-1:0] index_s;
  logic [31:0]       read_data_s;
  logic              addr_unused_s;

  assign index_s = word_index(bus.addr);

  // Byte-offset and high address bits carry no meaning for this memory.
  assign addr_unused_s = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

  // Storage array: cleared asynchronously while reset is low, otherwise a
  // store writes the whole addressed word on the rising edge. Because the
  // clear is asynchronous, a reset that lands on a clock edge drops the store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (bus.memwrite) begin
      mem_r[index_s] <= bus.write_data;
    end else begin
      mem_r[index_s] <= mem_r[index_s];
    end
  end

  // Load path: zero-latency read with no write-through bypass, so a load to a
  // word being stored shows the old contents until the clock edge.
  always_comb begin
    read_data_s = 32'h0000_0000;
    if (bus.memread) begin
      read_data_s = mem_r[index_s];
    end else begin
      read_data_s = 32'h0000_0000;
    end
  end

  assign bus.read_data = read_data_s;

endmodule : mips_data_memory

// File: tb/tb_mips_data_memory.sv
// -----------------------------------------------------------------------------
// tb_mips_data_memory
//   Directed-vector bench for mips_data_memory. The stimulus process drives the
//   bus and pushes the hand-computed expected load data into a scoreboard
//   queue; a separate monitor pops each entry and compares it against
//   read_data.
// -----------------------------------------------------------------------------
module tb_mips_data_memory;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_item_t;

  logic clk;
  logic reset;
  mips_data_memory_if bus ();

  sb_item_t sb_q[$];
  int       push_cnt;
  int       checks;
  int       failures;

  mips_data_memory #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares every queued expectation against the live load data.
  initial begin
    sb_item_t item;
    forever begin
      @(push_cnt);
      while (sb_q.size() != 0) begin
        item = sb_q.pop_front();
        checks++;
        if (bus.read_data !== item.exp) begin
          failures++;
          $display("FAIL %s: read_data=%h expected=%h", item.name, bus.read_data, item.exp);
        end
      end
    end
  end

  // Queue one expectation for the current bus state and let the monitor run.
  task automatic expect_data(input logic [31:0] exp, input string name);
    sb_item_t item;
    item.exp  = exp;
    item.name = name;
    sb_q.push_back(item);
    push_cnt++;
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr       = a;
    bus.write_data = d;
    bus.memwrite   = 1'b1;
    bus.memread    = 1'b0;
    @(negedge clk);
    bus.memwrite   = 1'b0;
  endtask

  task automatic read_check(input logic [31:0] a, input logic rd,
                            input logic [31:0] exp, input string name);
    @(negedge clk);
    bus.addr     = a;
    bus.memread  = rd;
    bus.memwrite = 1'b0;
    #1;
    expect_data(exp, name);
  endtask

  // Reads without waiting for a clock edge (used while reset is held).
  task automatic read_now(input logic [31:0] a, input logic [31:0] exp, input string name);
    bus.addr    = a;
    bus.memread = 1'b1;
    #1;
    expect_data(exp, name);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    push_cnt       = 0;
    reset          = 1'b0;
    bus.addr       = 32'h0;
    bus.memwrite   = 1'b0;
    bus.memread    = 1'b0;
    bus.write_data = 32'h0;

    // 1: reset state, including never-written and top-of-array words
    #9 reset = 1'b1;
    read_check(32'h0000_0000, 1'b1, 32'h0000_0000, "reset_0x000");
    read_check(32'h0000_0004, 1'b1, 32'h0000_0000, "reset_0x004");
    read_check(32'h0000_03FC, 1'b1, 32'h0000_0000, "reset_0x3fc");

    // 2: basic store/load and memread gating
    do_write(32'h0000_0010, 32'hDEAD_BEEF);
    read_check(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, "load_0x10");
    read_check(32'h0000_0010, 1'b0, 32'h0000_0000, "memread_low_0x10");

    // 3: byte offset ignored, high address bits wrap
    do_write(32'h0000_0020, 32'h1234_5678);
    read_check(32'h0000_0021, 1'b1, 32'h1234_5678, "misaligned_0x21");
    read_check(32'h0000_0023, 1'b1, 32'h1234_5678, "misaligned_0x23");
    read_check(32'h0000_0420, 1'b1, 32'h1234_5678, "wrap_0x420");
    do_write(32'hFFFF_FC28, 32'hCAFE_F00D);
    read_check(32'h0000_0028, 1'b1, 32'hCAFE_F00D, "wrap_store_0x28");
    read_check(32'h0000_0024, 1'b1, 32'h0000_0000, "neighbour_0x24");

    // 4: same-cycle load and store, no bypass
    do_write(32'h0000_0030, 32'h1111_1111);
    @(negedge clk);
    bus.addr       = 32'h0000_0030;
    bus.write_data = 32'h2222_2222;
    bus.memread    = 1'b1;
    bus.memwrite   = 1'b1;
    #1;
    expect_data(32'h1111_1111, "rw_before_edge");
    @(posedge clk);
    #1;
    expect_data(32'h2222_2222, "rw_after_edge");
    bus.memwrite = 1'b0;

    // 5: asynchronous mid-cycle reset clears everything and blocks stores
    do_write(32'h0000_0000, 32'h0000_0001);
    do_write(32'h0000_0004, 32'h0000_0002);
    do_write(32'h0000_0008, 32'h0000_0003);
    do_write(32'h0000_000C, 32'h0000_0004);
    read_check(32'h0000_0008, 1'b1, 32'h0000_0003, "fill_0x8");
    read_check(32'h0000_000C, 1'b1, 32'h0000_0004, "fill_0xc");
    @(negedge clk);
    #2 reset = 1'b0;
    read_now(32'h0000_0000, 32'h0000_0000, "async_rst_0x0");
    read_now(32'h0000_0004, 32'h0000_0000, "async_rst_0x4");
    read_now(32'h0000_0008, 32'h0000_0000, "async_rst_0x8");
    read_now(32'h0000_000C, 32'h0000_0000, "async_rst_0xc");
    read_now(32'h0000_0010, 32'h0000_0000, "async_rst_0x10");
    bus.addr       = 32'h0000_0000;
    bus.write_data = 32'hFFFF_FFFF;
    bus.memwrite   = 1'b1;
    @(posedge clk);
    #1;
    expect_data(32'h0000_0000, "write_during_reset");
    bus.memwrite = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    read_check(32'h0000_0000, 1'b1, 32'h0000_0000, "post_rst_0x0");
    read_check(32'h0000_0020, 1'b1, 32'h0000_0000, "post_rst_0x20");
    do_write(32'h0000_0000, 32'h0000_0077);
    read_check(32'h0000_0000, 1'b1, 32'h0000_0077, "first_write_after_rst");

    // 6: back-to-back stores on consecutive cycles
    @(negedge clk);
    bus.memread    = 1'b0;
    bus.addr       = 32'h0000_0040;
    bus.write_data = 32'hA5A5_A5A5;
    bus.memwrite   = 1'b1;
    @(negedge clk);
    bus.addr       = 32'h0000_0044;
    bus.write_data = 32'h5A5A_5A5A;
    @(negedge clk);
    bus.memwrite   = 1'b0;
    read_check(32'h0000_0040, 1'b1, 32'hA5A5_A5A5, "b2b_0x40");
    read_check(32'h0000_0044, 1'b1, 32'h5A5A_5A5A, "b2b_0x44");
    read_check(32'h0000_0048, 1'b1, 32'h0000_0000, "b2b_neighbour_0x48");

    // Drain the scoreboard within a bounded time.
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) #1;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mips_data_memory
